// File: rtl/ex_mdu_if.sv
// Operand/result bundle between the EX-stage issue logic and the multiply/divide unit.
// The master side issues operations and observes the stall request and the result strobe.
interface ex_mdu_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              start_i;
   logic [2:0]        funct3_i;
   logic [XLEN-1:0]   a_i;
   logic [XLEN-1:0]   b_i;
   logic [REG_AW-1:0] wd_i;
   logic              flush_i;
   logic              busy_o;
   logic              valid_o;
   logic [XLEN-1:0]   wdata_o;
   logic [REG_AW-1:0] wd_o;

   modport master (
      output start_i, funct3_i, a_i, b_i, wd_i, flush_i,
      input  busy_o, valid_o, wdata_o, wd_o
   );

   modport slave (
      input  start_i, funct3_i, a_i, b_i, wd_i, flush_i,
      output busy_o, valid_o, wdata_o, wd_o
   );
endinterface

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier, restoring divider,
// single-cycle fast path for divide-by-zero and signed overflow.
//  state | meaning
//  IDLE  | waiting for an op; start sampled here
//  MUL   | shift-add iterations, MUL_STEP multiplier bits per cycle
//  DIV   | restoring division, one quotient bit per cycle
//  DONE  | result strobe cycle, returns to IDLE
module ex_mdu #(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1,
   parameter int REG_AW   = 5
) (
   input logic   clk,
   input logic   rst,
   input logic   rdy,
   ex_mdu_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

   state_t              state;
   logic [CW-1:0]       count;
   logic [2:0]          f3;
   logic                sa, sb;
   logic [2*XLEN-1:0]   mcand, acc;
   logic [XLEN-1:0]     mplr, dvsr, quot, rmd;
   logic                valid_q;
   logic [XLEN-1:0]     wdata_q;
   logic [REG_AW-1:0]   wd_q, wd_lat;

   logic                accept, a_sop, b_sop, na, nb, is_div, b_zero, ovf;
   logic [XLEN-1:0]     mag_a, mag_b, fast_res;
   logic [2*XLEN-1:0]   mul_add, acc_nxt, mul_full;
   logic [XLEN-1:0]     mul_res;
   logic [XLEN:0]       r_sh, diff;
   logic                q_bit;
   logic [XLEN-1:0]     rmd_nxt, quot_nxt, div_q, div_r, div_res;

   assign accept = rdy & bus.start_i & ~bus.flush_i & (state == S_IDLE);

   // Operand preparation at accept: magnitudes plus sign flags
   always_comb begin
      a_sop    = (bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b010) |
                 (bus.funct3_i == 3'b100) | (bus.funct3_i == 3'b110);
      b_sop    = (bus.funct3_i == 3'b001) | (bus.funct3_i == 3'b100) |
                 (bus.funct3_i == 3'b110);
      na       = a_sop & bus.a_i[XLEN-1];
      nb       = b_sop & bus.b_i[XLEN-1];
      mag_a    = na ? -bus.a_i : bus.a_i;
      mag_b    = nb ? -bus.b_i : bus.b_i;
      is_div   = bus.funct3_i[2];
      b_zero   = (bus.b_i == '0);
      ovf      = ~bus.funct3_i[0] & (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b_i == '1);
      if (b_zero) fast_res = bus.funct3_i[1] ? bus.a_i : '1;
      else        fast_res = bus.funct3_i[1] ? '0 : bus.a_i;
   end

   always_comb begin
      mul_add = '0;
      for (int j = 0; j < MUL_STEP; j++) begin
         if (mplr[j]) mul_add = mul_add + (mcand << j);
      end
      acc_nxt  = acc + mul_add;
      mul_full = (sa ^ sb) ? -acc_nxt : acc_nxt;
      mul_res  = (f3 == 3'b000) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
   end

   // Restoring step: trial-subtract divisor from shifted partial remainder
   always_comb begin
      r_sh     = {rmd, quot[XLEN-1]};
      diff     = r_sh - {1'b0, dvsr};
      q_bit    = ~diff[XLEN];
      rmd_nxt  = q_bit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
      quot_nxt = {quot[XLEN-2:0], q_bit};
      div_q    = (sa ^ sb) ? -quot_nxt : quot_nxt;
      div_r    = sa ? -rmd_nxt : rmd_nxt;
      div_res  = f3[1] ? div_r : div_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         count   <= '0;
         f3      <= '0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         mcand   <= '0;
         acc     <= '0;
         mplr    <= '0;
         dvsr    <= '0;
         quot    <= '0;
         rmd     <= '0;
         valid_q <= 1'b0;
         wdata_q <= '0;
         wd_q    <= '0;
         wd_lat  <= '0;
      end else if (rdy) begin
         valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  f3     <= bus.funct3_i;
                  sa     <= na;
                  sb     <= nb;
                  count  <= '0;
                  wd_lat <= bus.wd_i;
                  mcand  <= {{XLEN{1'b0}}, mag_a};
                  mplr   <= mag_b;
                  acc    <= '0;
                  dvsr   <= mag_b;
                  quot   <= mag_a;
                  rmd    <= '0;
                  if (is_div & (b_zero | ovf)) begin
                     state   <= S_DONE;
                     valid_q <= 1'b1;
                     wdata_q <= fast_res;
                     wd_q    <= bus.wd_i;
                  end else begin
                     state <= is_div ? S_DIV : S_MUL;
                  end
               end
            end
            S_MUL: begin
               if (bus.flush_i) begin
                  state <= S_IDLE;
               end else begin
                  acc   <= acc_nxt;
                  mcand <= mcand << MUL_STEP;
                  mplr  <= mplr >> MUL_STEP;
                  count <= count + CW'(1);
                  if (count == MUL_LAST) begin
                     state   <= S_DONE;
                     valid_q <= 1'b1;
                     wdata_q <= mul_res;
                     wd_q    <= wd_lat;
                  end
               end
            end
            S_DIV: begin
               if (bus.flush_i) begin
                  state <= S_IDLE;
               end else begin
                  rmd   <= rmd_nxt;
                  quot  <= quot_nxt;
                  count <= count + CW'(1);
                  if (count == DIV_LAST) begin
                     state   <= S_DONE;
                     valid_q <= 1'b1;
                     wdata_q <= div_res;
                     wd_q    <= wd_lat;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy_o  = accept | (state == S_MUL) | (state == S_DIV);
   assign bus.valid_o = valid_q;
   assign bus.wdata_o = wdata_q;
   assign bus.wd_o    = wd_q;
endmodule
